acc_sequencer: RTL and testbench

//   Owns a node's ACC and BAK registers and sequences one ALU op at a time: ADD, SUB, NEG, MOV, SWP, SAV.

---
 rtl/acc_sequencer.sv | 175 +++++++++++++++++
 tb/tb_acc_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_sequencer.sv
// ACC/BAK owner: sequences one saturating ALU op at a time,
// with operands from an immediate or a handshaked port.
module acc_sequencer #(
  parameter int WIDTH   = 11,
  parameter int SAT_MAX = 999
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    op_valid,
  output logic                    op_ready,
  input  logic [2:0]              op_code,
  input  logic                    src_sel,
  input  logic signed [WIDTH-1:0] imm,
  input  logic                    port_valid,
  input  logic signed [WIDTH-1:0] port_data,
  output logic                    port_ready,
  output logic signed [WIDTH-1:0] acc,
  output logic signed [WIDTH-1:0] bak,
  output logic                    done,
  output logic                    sat
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_EXEC
  } state_t;

  localparam logic [2:0] OP_MOV = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_NEG = 3'd4;
  localparam logic [2:0] OP_SWP = 3'd5;
  localparam logic [2:0] OP_SAV = 3'd6;

  localparam logic signed [WIDTH:0] MAXV = (WIDTH+1)'(SAT_MAX);
  localparam logic signed [WIDTH:0] MINV = -MAXV;

  function automatic logic signed [WIDTH:0] clamp(
    input logic signed [WIDTH:0] v
  );
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
  endfunction

  state_t                  state_q, state_d;
  logic [2:0]              op_q, op_d;
  logic signed [WIDTH-1:0] opnd_q, opnd_d;
  logic signed [WIDTH-1:0] acc_q, acc_d;
  logic signed [WIDTH-1:0] bak_q, bak_d;
  logic                    done_q, done_d;
  logic                    sat_q, sat_d;

  logic                    needs_port;
  logic                    is_mov, is_add, is_sub;
  logic                    is_neg, is_swp, is_sav;
  logic                    arith, use_x, x_clip;
  logic signed [WIDTH:0]   x_ext, x_c, a_ext, r, r_c;
  logic signed [WIDTH-1:0] res_acc, res_bak;
  logic                    res_sat;

  assign op_ready   = rst_n && (state_q == S_IDLE) && !done_q;
  assign port_ready = rst_n && (state_q == S_WAIT);
  assign acc        = acc_q;
  assign bak        = bak_q;
  assign done       = done_q;
  assign sat        = sat_q;

  assign needs_port = src_sel &&
    (op_code == OP_MOV || op_code == OP_ADD ||
     op_code == OP_SUB);

  assign is_mov = (op_q == OP_MOV);
  assign is_add = (op_q == OP_ADD);
  assign is_sub = (op_q == OP_SUB);
  assign is_neg = (op_q == OP_NEG);
  assign is_swp = (op_q == OP_SWP);
  assign is_sav = (op_q == OP_SAV);
  assign arith  = is_mov | is_add | is_sub | is_neg;

  // one extra bit holds any sum of two clamped values
  assign x_ext  = {opnd_q[WIDTH-1], opnd_q};
  assign a_ext  = {acc_q[WIDTH-1], acc_q};
  assign x_c    = clamp(x_ext);
  assign x_clip = (x_c != x_ext);

  always_comb begin
    r       = a_ext;
    use_x   = 1'b0;
    res_acc = acc_q;
    res_bak = bak_q;
    res_sat = 1'b0;
    unique case (1'b1)
      is_mov: begin
        r     = x_c;
        use_x = 1'b1;
      end
      is_add: begin
        r     = a_ext + x_c;
        use_x = 1'b1;
      end
      is_sub: begin
        r     = a_ext - x_c;
        use_x = 1'b1;
      end
      is_neg:  r = -a_ext;
      default: r = a_ext;
    endcase
    r_c = clamp(r);
    if (arith) begin
      res_acc = r_c[WIDTH-1:0];
      res_sat = (r_c != r) | (use_x & x_clip);
    end
    if (is_swp) begin
      res_acc = bak_q;
      res_bak = acc_q;
    end
    if (is_sav) res_bak = acc_q;
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    bak_d   = bak_q;
    done_d  = 1'b0;
    sat_d   = sat_q;
    unique case (state_q)
      S_IDLE: begin
        if (op_valid && op_ready) begin
          op_d    = op_code;
          opnd_d  = imm;
          state_d = needs_port ? S_WAIT : S_EXEC;
        end
      end
      S_WAIT: begin
        if (port_valid) begin
          opnd_d  = port_data;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        acc_d   = res_acc;
        bak_d   = res_bak;
        done_d  = 1'b1;
        sat_d   = res_sat;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      bak_q   <= '0;
      done_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      bak_q   <= bak_d;
      done_q  <= done_d;
      sat_q   <= sat_d;
    end
  end

endmodule

// File: tb/tb_acc_sequencer.sv
// Directed bench for acc_sequencer: reset, saturation,
// port handshake, register moves and reset mid-op.
module tb_acc_sequencer;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               op_valid;
  logic               op_ready;
  logic [2:0]         op_code;
  logic               src_sel;
  logic signed [10:0] imm;
  logic               port_valid;
  logic signed [10:0] port_data;
  logic               port_ready;
  logic signed [10:0] acc;
  logic signed [10:0] bak;
  logic               done;
  logic               sat;

  int n_cmp = 0;
  int n_err = 0;

  acc_sequencer #(.WIDTH(11), .SAT_MAX(999)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_code    (op_code),
    .src_sel    (src_sel),
    .imm        (imm),
    .port_valid (port_valid),
    .port_data  (port_data),
    .port_ready (port_ready),
    .acc        (acc),
    .bak        (bak),
    .done       (done),
    .sat        (sat)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Returns at the negedge after the accepting edge.
  task automatic issue(input logic [2:0] c, input logic s,
                       input logic signed [10:0] v);
    int i;
    @(negedge clk);
    op_valid = 1'b1;
    op_code  = c;
    src_sel  = s;
    imm      = v;
    i = 0;
    while (!op_ready && i < 20) begin
      @(negedge clk);
      i++;
    end
    n_cmp++;
    if (op_ready !== 1'b1) begin
      n_err++;
      $display("FAIL issue_accept op=%0d op_ready=%b required 1",
               c, op_ready);
    end
    @(negedge clk);
    op_valid = 1'b0;
    op_code  = 3'd0;
    src_sel  = 1'b0;
    imm      = '0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (op_ready !== 1'b0 || port_ready !== 1'b0) begin
      n_err++;
      $display("FAIL rst_ready op_ready=%b port_ready=%b required 0/0",
               op_ready, port_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (acc !== 11'sd0 || bak !== 11'sd0) begin
      n_err++;
      $display("FAIL rst_regs acc=%0d bak=%0d required 0/0", acc, bak);
    end
    n_cmp++;
    if (done !== 1'b0 || sat !== 1'b0) begin
      n_err++;
      $display("FAIL rst_flags done=%b sat=%b required 0/0", done, sat);
    end
    n_cmp++;
    if (op_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rst_op_ready got=%b required 1", op_ready);
    end
  endtask

  task automatic test_imm_ops;
    issue(3'd1, 1'b0, 11'sd52);
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL mov_early_done got=%b required 0", done);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b1 || acc !== 11'sd52 || sat !== 1'b0) begin
      n_err++;
      $display("FAIL mov52 done=%b acc=%0d sat=%b required 1/52/0",
               done, acc, sat);
    end
    n_cmp++;
    if (op_ready !== 1'b0) begin
      n_err++;
      $display("FAIL ready_during_done got=%b required 0", op_ready);
    end
    issue(3'd3, 1'b0, -11'sd53);
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL sub_early_done got=%b required 0", done);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b1 || acc !== 11'sd105 || sat !== 1'b0) begin
      n_err++;
      $display("FAIL sub_neg53 done=%b acc=%0d sat=%b required 1/105/0",
               done, acc, sat);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL done_pulse got=%b required 0", done);
    end
  endtask

  task automatic test_saturation;
    issue(3'd1, 1'b0, -11'sd951);
    @(negedge clk);
    issue(3'd3, 1'b0, 11'sd902);
    @(negedge clk);
    n_cmp++;
    if (acc !== -11'sd999 || sat !== 1'b1) begin
      n_err++;
      $display("FAIL sub_clamp acc=%0d sat=%b required -999/1", acc, sat);
    end
    @(negedge clk);
    n_cmp++;
    if (sat !== 1'b1) begin
      n_err++;
      $display("FAIL sat_sticky got=%b required 1", sat);
    end
    issue(3'd2, 1'b0, 11'sd900);
    @(negedge clk);
    n_cmp++;
    if (acc !== -11'sd99 || sat !== 1'b0) begin
      n_err++;
      $display("FAIL add900 acc=%0d sat=%b required -99/0", acc, sat);
    end
    issue(3'd1, 1'b0, 11'sd1023);
    @(negedge clk);
    n_cmp++;
    if (acc !== 11'sd999 || sat !== 1'b1) begin
      n_err++;
      $display("FAIL mov_in_clip acc=%0d sat=%b required 999/1", acc, sat);
    end
    issue(3'd7, 1'b0, 11'sd5);
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b1 || acc !== 11'sd999 || sat !== 1'b0) begin
      n_err++;
      $display("FAIL reserved done=%b acc=%0d sat=%b required 1/999/0",
               done, acc, sat);
    end
    issue(3'd1, 1'b0, -11'sd1024);
    @(negedge clk);
    n_cmp++;
    if (acc !== -11'sd999 || sat !== 1'b1) begin
      n_err++;
      $display("FAIL mov_min acc=%0d sat=%b required -999/1", acc, sat);
    end
    issue(3'd4, 1'b0, 11'sd0);
    @(negedge clk);
    n_cmp++;
    if (acc !== 11'sd999 || sat !== 1'b0) begin
      n_err++;
      $display("FAIL neg_min acc=%0d sat=%b required 999/0", acc, sat);
    end
  endtask

  task automatic test_port;
    issue(3'd1, 1'b0, 11'sd100);
    @(negedge clk);
    @(negedge clk);
    port_valid = 1'b1;
    port_data  = 11'sd500;
    n_cmp++;
    if (port_ready !== 1'b0) begin
      n_err++;
      $display("FAIL idle_port_ready got=%b required 0", port_ready);
    end
    @(negedge clk);
    n_cmp++;
    if (port_ready !== 1'b0 || acc !== 11'sd100) begin
      n_err++;
      $display("FAIL idle_port_ignore port_ready=%b acc=%0d required 0/100",
               port_ready, acc);
    end
    port_valid = 1'b0;
    issue(3'd2, 1'b1, 11'sd0);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (port_ready !== 1'b1 || acc !== 11'sd100 || done !== 1'b0) begin
        n_err++;
        $display("FAIL port_wait%0d port_ready=%b acc=%0d done=%b required 1/100/0",
                 i, port_ready, acc, done);
      end
      @(negedge clk);
    end
    port_valid = 1'b1;
    port_data  = 11'sd27;
    @(negedge clk);
    port_valid = 1'b0;
    n_cmp++;
    if (port_ready !== 1'b0 || acc !== 11'sd100) begin
      n_err++;
      $display("FAIL port_take port_ready=%b acc=%0d required 0/100",
               port_ready, acc);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b1 || acc !== 11'sd127 || sat !== 1'b0) begin
      n_err++;
      $display("FAIL port_add done=%b acc=%0d sat=%b required 1/127/0",
               done, acc, sat);
    end
  endtask

  task automatic test_moves;
    issue(3'd1, 1'b0, 11'sd27);
    @(negedge clk);
    issue(3'd6, 1'b0, 11'sd0);
    @(negedge clk);
    n_cmp++;
    if (bak !== 11'sd27 || acc !== 11'sd27) begin
      n_err++;
      $display("FAIL sav acc=%0d bak=%0d required 27/27", acc, bak);
    end
    issue(3'd1, 1'b0, -11'sd25);
    @(negedge clk);
    issue(3'd5, 1'b0, 11'sd0);
    @(negedge clk);
    n_cmp++;
    if (acc !== 11'sd27 || bak !== -11'sd25) begin
      n_err++;
      $display("FAIL swp acc=%0d bak=%0d required 27/-25", acc, bak);
    end
    issue(3'd4, 1'b0, 11'sd0);
    @(negedge clk);
    n_cmp++;
    if (acc !== -11'sd27 || bak !== -11'sd25 || sat !== 1'b0) begin
      n_err++;
      $display("FAIL neg acc=%0d bak=%0d sat=%b required -27/-25/0",
               acc, bak, sat);
    end
  endtask

  task automatic test_reset_in_wait;
    issue(3'd2, 1'b1, 11'sd0);
    n_cmp++;
    if (port_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rw_wait port_ready=%b required 1", port_ready);
    end
    rst_n      = 1'b0;
    port_valid = 1'b1;
    port_data  = 11'sd5;
    @(negedge clk);
    n_cmp++;
    if (port_ready !== 1'b0 || op_ready !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL rw_hold port_ready=%b op_ready=%b done=%b required 0/0/0",
               port_ready, op_ready, done);
    end
    n_cmp++;
    if (acc !== 11'sd0 || bak !== 11'sd0) begin
      n_err++;
      $display("FAIL rw_regs acc=%0d bak=%0d required 0/0", acc, bak);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (op_ready !== 1'b1 || port_ready !== 1'b0 ||
        acc !== 11'sd0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL rw_release op_ready=%b port_ready=%b acc=%0d done=%b required 1/0/0/0",
               op_ready, port_ready, acc, done);
    end
    port_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || acc !== 11'sd0) begin
      n_err++;
      $display("FAIL rw_after done=%b acc=%0d required 0/0", done, acc);
    end
    issue(3'd1, 1'b0, 11'sd7);
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b1 || acc !== 11'sd7) begin
      n_err++;
      $display("FAIL rw_resume done=%b acc=%0d required 1/7", done, acc);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    op_valid   = 1'b0;
    op_code    = 3'd0;
    src_sel    = 1'b0;
    imm        = '0;
    port_valid = 1'b0;
    port_data  = '0;
    test_reset();
    test_imm_ops();
    test_saturation();
    test_port();
    test_moves();
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
